// File: rtl/la_wb_master_pkg.sv
// Shared types and response codes for the logic-analyzer driven Wishbone master.
package la_wb_master_pkg;

   typedef enum logic [1:0] {
      ST_IDLE = 2'd0,
      ST_BUS  = 2'd1,
      ST_GAP  = 2'd2
   } state_t;

   localparam logic [1:0] RSP_OK      = 2'b00;
   localparam logic [1:0] RSP_TIMEOUT = 2'b01;
   localparam logic [1:0] RSP_OVERRUN = 2'b10;

endpackage

// File: rtl/la_wb_master_if.sv
// Wishbone classic bus between the LA bridge (master) and the harness (slave).
interface la_wb_master_if;

   logic        wbm_cyc_o;
   logic        wbm_stb_o;
   logic        wbm_we_o;
   logic [3:0]  wbm_sel_o;
   logic [31:0] wbm_adr_o;
   logic [31:0] wbm_dat_o;
   logic        wbm_ack_i;
   logic [31:0] wbm_dat_i;

   modport master (
      output wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      input  wbm_ack_i, wbm_dat_i
   );

   modport slave (
      input  wbm_cyc_o, wbm_stb_o, wbm_we_o, wbm_sel_o, wbm_adr_o, wbm_dat_o,
      output wbm_ack_i, wbm_dat_i
   );

endinterface

// File: rtl/la_wb_master_toggle_sync.sv
// Synchronizes the LA command toggle and turns each edge into a one-cycle pulse.
// The pulse is registered, so it appears SYNC_STAGES+1 cycles after the input moves.
module la_wb_master_toggle_sync #(
   parameter int SYNC_STAGES = 2
) (
   input  logic clk_i,
   input  logic rst_i,
   input  logic tgl_i,
   output logic pulse_o
);

   logic [SYNC_STAGES-1:0] sync_q;
   logic                   ref_q;
   logic                   pulse_q;

   // Synchronizer chain, edge-reference flop and registered edge pulse.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         sync_q  <= '0;
         ref_q   <= 1'b0;
         pulse_q <= 1'b0;
      end else begin
         sync_q  <= {sync_q[SYNC_STAGES-2:0], tgl_i};
         ref_q   <= sync_q[SYNC_STAGES-1];
         pulse_q <= sync_q[SYNC_STAGES-1] ^ ref_q;
      end
   end

   assign pulse_o = pulse_q;

endmodule

// File: rtl/la_wb_master.sv
// LA-command driven Wishbone classic master: one single transfer per command
// toggle, with a response toggle, read data and status returned to the LA.
//
//  state | meaning
//  IDLE  | waiting for a command edge
//  BUS   | cyc/stb asserted, waiting for ack or timeout
//  GAP   | one dead cycle with cyc low; a stale registered ack is ignored here
module la_wb_master
   import la_wb_master_pkg::*;
#(
   parameter int SYNC_STAGES = 2,
   parameter int TIMEOUT     = 200,
   parameter int TIMEOUT_W   = 8
) (
   input  logic                 wb_clk_i,
   input  logic                 wb_rst_i,
   input  logic                 cmd_tgl_i,
   input  logic                 cmd_we_i,
   input  logic [3:0]           cmd_sel_i,
   input  logic [31:0]          cmd_adr_i,
   input  logic [31:0]          cmd_dat_i,
   output logic                 rsp_tgl_o,
   output logic [31:0]          rsp_dat_o,
   output logic [1:0]           rsp_status_o,
   output logic                 busy_o,
   la_wb_master_if.master       wbm
);

   localparam logic [TIMEOUT_W-1:0] CNT_LAST = TIMEOUT_W'(TIMEOUT - 1);

   logic                 cmd_edge;
   state_t               state_q,      state_d;
   logic [TIMEOUT_W-1:0] cnt_q,        cnt_d;
   logic                 cyc_q,        cyc_d;
   logic                 we_q,         we_d;
   logic [3:0]           sel_q,        sel_d;
   logic [31:0]          adr_q,        adr_d;
   logic [31:0]          dat_q,        dat_d;
   logic                 rsp_tgl_q,    rsp_tgl_d;
   logic [31:0]          rsp_dat_q,    rsp_dat_d;
   logic [1:0]           rsp_status_q, rsp_status_d;
   logic                 busy_q,       busy_d;
   logic                 ovr_pend_q,   ovr_pend_d;

   la_wb_master_toggle_sync #(
      .SYNC_STAGES (SYNC_STAGES)
   ) u_toggle_sync (
      .clk_i   (wb_clk_i),
      .rst_i   (wb_rst_i),
      .tgl_i   (cmd_tgl_i),
      .pulse_o (cmd_edge)
   );

   // Next-state and registered-output logic for the transfer FSM.
   always_comb begin
      state_d      = state_q;
      cnt_d        = cnt_q;
      cyc_d        = cyc_q;
      we_d         = we_q;
      sel_d        = sel_q;
      adr_d        = adr_q;
      dat_d        = dat_q;
      rsp_tgl_d    = rsp_tgl_q;
      rsp_dat_d    = rsp_dat_q;
      rsp_status_d = rsp_status_q;
      ovr_pend_d   = ovr_pend_q;

      case (state_q)
         ST_IDLE: begin
            if (cmd_edge) begin
               we_d       = cmd_we_i;
               sel_d      = cmd_sel_i;
               adr_d      = cmd_adr_i;
               dat_d      = cmd_dat_i;
               cyc_d      = 1'b1;
               cnt_d      = '0;
               ovr_pend_d = 1'b0;
               state_d    = ST_BUS;
            end
         end
         ST_BUS: begin
            cnt_d = cnt_q + TIMEOUT_W'(1);
            if (wbm.wbm_ack_i) begin
               cyc_d        = 1'b0;
               rsp_dat_d    = we_q ? 32'h0 : wbm.wbm_dat_i;
               rsp_status_d = RSP_OK;
               rsp_tgl_d    = ~rsp_tgl_q;
               ovr_pend_d   = cmd_edge;
               state_d      = ST_GAP;
            end else if (cnt_q == CNT_LAST) begin
               cyc_d        = 1'b0;
               rsp_dat_d    = 32'h0;
               rsp_status_d = RSP_TIMEOUT;
               rsp_tgl_d    = ~rsp_tgl_q;
               ovr_pend_d   = cmd_edge;
               state_d      = ST_GAP;
            end else if (cmd_edge) begin
               // Dropped command: report it now, leave the transfer alone.
               rsp_status_d = RSP_OVERRUN;
               rsp_tgl_d    = ~rsp_tgl_q;
            end
         end
         ST_GAP: begin
            // A drop that collided with completion is reported here so the
            // response toggle never flips twice in one cycle.
            if (cmd_edge || ovr_pend_q) begin
               rsp_status_d = RSP_OVERRUN;
               rsp_tgl_d    = ~rsp_tgl_q;
            end
            ovr_pend_d = 1'b0;
            state_d    = ST_IDLE;
         end
         default: begin
            cyc_d   = 1'b0;
            state_d = ST_IDLE;
         end
      endcase

      busy_d = (state_d != ST_IDLE);
   end

   // State, bus and response registers; reset drops the bus immediately.
   always_ff @(posedge wb_clk_i or posedge wb_rst_i) begin
      if (wb_rst_i) begin
         state_q      <= ST_IDLE;
         cnt_q        <= '0;
         cyc_q        <= 1'b0;
         we_q         <= 1'b0;
         sel_q        <= '0;
         adr_q        <= '0;
         dat_q        <= '0;
         rsp_tgl_q    <= 1'b0;
         rsp_dat_q    <= '0;
         rsp_status_q <= RSP_OK;
         busy_q       <= 1'b0;
         ovr_pend_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         cnt_q        <= cnt_d;
         cyc_q        <= cyc_d;
         we_q         <= we_d;
         sel_q        <= sel_d;
         adr_q        <= adr_d;
         dat_q        <= dat_d;
         rsp_tgl_q    <= rsp_tgl_d;
         rsp_dat_q    <= rsp_dat_d;
         rsp_status_q <= rsp_status_d;
         busy_q       <= busy_d;
         ovr_pend_q   <= ovr_pend_d;
      end
   end

   assign wbm.wbm_cyc_o = cyc_q;
   assign wbm.wbm_stb_o = cyc_q;
   assign wbm.wbm_we_o  = we_q;
   assign wbm.wbm_sel_o = sel_q;
   assign wbm.wbm_adr_o = adr_q;
   assign wbm.wbm_dat_o = dat_q;

   assign rsp_tgl_o    = rsp_tgl_q;
   assign rsp_dat_o    = rsp_dat_q;
   assign rsp_status_o = rsp_status_q;
   assign busy_o       = busy_q;

endmodule

// File: tb/tb_la_wb_master.sv
// Directed bench for la_wb_master against a small harness-like slave model
// whose ack is registered and stays high one extra cycle (stale ack).
module tb_la_wb_master;

   localparam int SYNC_STAGES = 2;
   localparam int TIMEOUT     = 200;
   localparam int TIMEOUT_W   = 8;
   localparam int LAT         = SYNC_STAGES + 4;

   logic        clk = 1'b0;
   logic        rst = 1'b1;
   logic        cmd_tgl = 1'b0;
   logic        cmd_we = 1'b0;
   logic [3:0]  cmd_sel = 4'h0;
   logic [31:0] cmd_adr = 32'h0;
   logic [31:0] cmd_dat = 32'h0;
   logic        rsp_tgl_o;
   logic [31:0] rsp_dat_o;
   logic [1:0]  rsp_status_o;
   logic        busy_o;

   logic        exp_tgl = 1'b0;
   int          checks = 0;
   int          passed = 0;

   always #50 clk = ~clk;

   la_wb_master_if wbm ();

   la_wb_master #(
      .SYNC_STAGES (SYNC_STAGES),
      .TIMEOUT     (TIMEOUT),
      .TIMEOUT_W   (TIMEOUT_W)
   ) dut (
      .wb_clk_i     (clk),
      .wb_rst_i     (rst),
      .cmd_tgl_i    (cmd_tgl),
      .cmd_we_i     (cmd_we),
      .cmd_sel_i    (cmd_sel),
      .cmd_adr_i    (cmd_adr),
      .cmd_dat_i    (cmd_dat),
      .rsp_tgl_o    (rsp_tgl_o),
      .rsp_dat_o    (rsp_dat_o),
      .rsp_status_o (rsp_status_o),
      .busy_o       (busy_o),
      .wbm          (wbm)
   );

   // Slave model: 64 words at 0x30000000, anything else never acks.
   logic [31:0] mem [0:63];
   logic        ack_q;
   logic [31:0] rd_q;
   int          wr_total = 0;
   logic        mapped;

   assign mapped        = (wbm.wbm_adr_o[31:8] == 24'h300000);
   assign wbm.wbm_ack_i = ack_q;
   assign wbm.wbm_dat_i = rd_q;

   always @(posedge clk or posedge rst) begin
      if (rst) begin
         ack_q <= 1'b0;
         rd_q  <= 32'h0;
         for (int i = 0; i < 64; i++) mem[i] <= 32'h0;
      end else begin
         ack_q <= wbm.wbm_cyc_o & wbm.wbm_stb_o & mapped;
         rd_q  <= mem[wbm.wbm_adr_o[7:2]];
         if (wbm.wbm_cyc_o && wbm.wbm_stb_o && wbm.wbm_we_o && mapped && !ack_q) begin
            for (int b = 0; b < 4; b++)
               if (wbm.wbm_sel_o[b]) mem[wbm.wbm_adr_o[7:2]][8*b +: 8] <= wbm.wbm_dat_o[8*b +: 8];
            wr_total <= wr_total + 1;
         end
      end
   end

   // Bus activity counters.
   int   cyc_total = 0;
   int   stb_rise_total = 0;
   int   gap_total = 0;
   int   flip_total = 0;
   int   stb_cyc_diff = 0;
   logic stb_prev = 1'b0;
   logic tgl_prev = 1'b0;

   always @(posedge clk) begin
      if (wbm.wbm_cyc_o) cyc_total <= cyc_total + 1;
      if (wbm.wbm_stb_o && !stb_prev) stb_rise_total <= stb_rise_total + 1;
      if (busy_o && !wbm.wbm_cyc_o) gap_total <= gap_total + 1;
      if (rsp_tgl_o != tgl_prev) flip_total <= flip_total + 1;
      if (wbm.wbm_stb_o != wbm.wbm_cyc_o) stb_cyc_diff <= stb_cyc_diff + 1;
      stb_prev <= wbm.wbm_stb_o;
      tgl_prev <= rsp_tgl_o;
   end

   task automatic issue(input logic we, input logic [3:0] sel, input logic [31:0] adr,
                        input logic [31:0] dat);
      @(negedge clk);
      cmd_we  = we;
      cmd_sel = sel;
      cmd_adr = adr;
      cmd_dat = dat;
      repeat (SYNC_STAGES + 2) @(negedge clk);
      cmd_tgl = ~cmd_tgl;
   endtask

   // Counts negedges until the response toggle departs from exp_tgl (bounded).
   task automatic wait_rsp(input int n0, output int n);
      n = n0;
      while (n < 1000 && rsp_tgl_o === exp_tgl) begin
         @(negedge clk);
         n++;
      end
   endtask

   task automatic test_reset();
      repeat (3) @(negedge clk);
      checks++;
      if ({wbm.wbm_cyc_o, wbm.wbm_stb_o, busy_o, rsp_tgl_o} !== 4'b0000)
         $display("FAIL reset_ctrl: got %b expected 0000", {wbm.wbm_cyc_o, wbm.wbm_stb_o, busy_o, rsp_tgl_o});
      else passed++;
      checks++;
      if (rsp_dat_o !== 32'h0) $display("FAIL reset_rsp_dat: got %h expected 00000000", rsp_dat_o);
      else passed++;
      checks++;
      if (rsp_status_o !== 2'b00) $display("FAIL reset_status: got %b expected 00", rsp_status_o);
      else passed++;
      rst = 1'b0;
   endtask

   task automatic test_write();
      int n;
      int stb0, wr0, gap0;
      stb0 = stb_rise_total; wr0 = wr_total; gap0 = gap_total;
      issue(1'b1, 4'h1, 32'h3000_0000, 32'h0000_0003);
      wait_rsp(0, n);
      checks++;
      if (n !== LAT) $display("FAIL wr_latency: got %0d expected %0d", n, LAT);
      else passed++;
      exp_tgl = ~exp_tgl;
      checks++;
      if (rsp_status_o !== 2'b00) $display("FAIL wr_status: got %b expected 00", rsp_status_o);
      else passed++;
      checks++;
      if (rsp_dat_o !== 32'h0) $display("FAIL wr_rsp_dat: got %h expected 00000000", rsp_dat_o);
      else passed++;
      checks++;
      if (busy_o !== 1'b1) $display("FAIL wr_busy_in_gap: got %b expected 1", busy_o);
      else passed++;
      @(negedge clk);
      checks++;
      if (busy_o !== 1'b0) $display("FAIL wr_busy_idle: got %b expected 0", busy_o);
      else passed++;
      repeat (2) @(negedge clk);
      checks++;
      if (stb_rise_total - stb0 !== 1) $display("FAIL wr_stb_pulses: got %0d expected 1", stb_rise_total - stb0);
      else passed++;
      checks++;
      if (wr_total - wr0 !== 1) $display("FAIL wr_count: got %0d expected 1", wr_total - wr0);
      else passed++;
      checks++;
      if (gap_total - gap0 !== 1) $display("FAIL wr_gap_cycles: got %0d expected 1", gap_total - gap0);
      else passed++;
   endtask

   task automatic test_read();
      int n;
      int fl0;
      fl0 = flip_total;
      issue(1'b0, 4'hF, 32'h3000_0000, 32'hDEAD_BEEF);
      wait_rsp(0, n);
      checks++;
      if (n !== LAT) $display("FAIL rd_latency: got %0d expected %0d", n, LAT);
      else passed++;
      exp_tgl = ~exp_tgl;
      checks++;
      if (rsp_dat_o !== 32'h0000_0003) $display("FAIL rd_data: got %h expected 00000003", rsp_dat_o);
      else passed++;
      checks++;
      if (rsp_status_o !== 2'b00) $display("FAIL rd_status: got %b expected 00", rsp_status_o);
      else passed++;
      repeat (3) @(negedge clk);
      checks++;
      if (flip_total - fl0 !== 1) $display("FAIL rd_flips: got %0d expected 1", flip_total - fl0);
      else passed++;
   endtask

   task automatic test_overrun_in_bus();
      int n;
      int wr0;
      wr0 = wr_total;
      issue(1'b1, 4'hF, 32'h3000_0004, 32'hA5A5_5A5A);
      @(negedge clk);
      cmd_tgl = ~cmd_tgl;
      wait_rsp(1, n);
      checks++;
      if (n !== LAT - 1) $display("FAIL ovr_latency: got %0d expected %0d", n, LAT - 1);
      else passed++;
      exp_tgl = ~exp_tgl;
      checks++;
      if (rsp_status_o !== 2'b10) $display("FAIL ovr_status: got %b expected 10", rsp_status_o);
      else passed++;
      checks++;
      if (rsp_dat_o !== 32'h0000_0003) $display("FAIL ovr_rsp_dat_kept: got %h expected 00000003", rsp_dat_o);
      else passed++;
      checks++;
      if (wbm.wbm_cyc_o !== 1'b1) $display("FAIL ovr_inflight_cyc: got %b expected 1", wbm.wbm_cyc_o);
      else passed++;
      wait_rsp(n, n);
      checks++;
      if (n !== LAT) $display("FAIL ovr_completion_latency: got %0d expected %0d", n, LAT);
      else passed++;
      exp_tgl = ~exp_tgl;
      checks++;
      if ({rsp_status_o, rsp_dat_o} !== {2'b00, 32'h0}) $display("FAIL ovr_completion: got %b/%h expected 00/00000000", rsp_status_o, rsp_dat_o);
      else passed++;
      repeat (3) @(negedge clk);
      checks++;
      if (wr_total - wr0 !== 1) $display("FAIL ovr_write_count: got %0d expected 1", wr_total - wr0);
      else passed++;
      checks++;
      if (mem[1] !== 32'hA5A5_5A5A) $display("FAIL ovr_mem: got %h expected a5a55a5a", mem[1]);
      else passed++;
   endtask

   task automatic test_overrun_at_completion();
      int n;
      issue(1'b0, 4'hF, 32'h3000_0004, 32'h0);
      repeat (2) @(negedge clk);
      cmd_tgl = ~cmd_tgl;
      wait_rsp(2, n);
      checks++;
      if (n !== LAT) $display("FAIL coll_completion_latency: got %0d expected %0d", n, LAT);
      else passed++;
      exp_tgl = ~exp_tgl;
      checks++;
      if ({rsp_status_o, rsp_dat_o} !== {2'b00, 32'hA5A5_5A5A}) $display("FAIL coll_completion: got %b/%h expected 00/a5a55a5a", rsp_status_o, rsp_dat_o);
      else passed++;
      wait_rsp(n, n);
      checks++;
      if (n !== LAT + 1) $display("FAIL coll_deferred_latency: got %0d expected %0d", n, LAT + 1);
      else passed++;
      exp_tgl = ~exp_tgl;
      checks++;
      if ({rsp_status_o, rsp_dat_o} !== {2'b10, 32'hA5A5_5A5A}) $display("FAIL coll_deferred: got %b/%h expected 10/a5a55a5a", rsp_status_o, rsp_dat_o);
      else passed++;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_timeout();
      int n;
      int cyc0;
      cyc0 = cyc_total;
      issue(1'b1, 4'hF, 32'h3000_0FF0, 32'h1234_5678);
      wait_rsp(0, n);
      checks++;
      if (n !== TIMEOUT + 4) $display("FAIL tmo_latency: got %0d expected %0d", n, TIMEOUT + 4);
      else passed++;
      exp_tgl = ~exp_tgl;
      checks++;
      if (rsp_status_o !== 2'b01) $display("FAIL tmo_status: got %b expected 01", rsp_status_o);
      else passed++;
      checks++;
      if (rsp_dat_o !== 32'h0) $display("FAIL tmo_rsp_dat: got %h expected 00000000", rsp_dat_o);
      else passed++;
      repeat (3) @(negedge clk);
      checks++;
      if (cyc_total - cyc0 !== TIMEOUT) $display("FAIL tmo_cyc_cycles: got %0d expected %0d", cyc_total - cyc0, TIMEOUT);
      else passed++;
   endtask

   task automatic test_reset_mid_bus();
      int n;
      int wr0;
      wr0 = wr_total;
      issue(1'b1, 4'hF, 32'h3000_0008, 32'h1111_1111);
      repeat (SYNC_STAGES + 2) @(negedge clk);
      checks++;
      if (wbm.wbm_cyc_o !== 1'b1) $display("FAIL rst_pre_cyc: got %b expected 1", wbm.wbm_cyc_o);
      else passed++;
      #10 rst = 1'b1;
      #1;
      checks++;
      if ({wbm.wbm_cyc_o, wbm.wbm_stb_o, busy_o} !== 3'b000) $display("FAIL rst_async_drop: got %b expected 000", {wbm.wbm_cyc_o, wbm.wbm_stb_o, busy_o});
      else passed++;
      cmd_tgl = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      exp_tgl = 1'b0;
      repeat (10) @(negedge clk);
      checks++;
      if (rsp_tgl_o !== 1'b0) $display("FAIL rst_no_rsp: got %b expected 0", rsp_tgl_o);
      else passed++;
      checks++;
      if (wr_total - wr0 !== 0) $display("FAIL rst_no_write: got %0d expected 0", wr_total - wr0);
      else passed++;
      issue(1'b1, 4'hF, 32'h3000_0008, 32'h2222_2222);
      wait_rsp(0, n);
      checks++;
      if (n !== LAT) $display("FAIL rst_after_latency: got %0d expected %0d", n, LAT);
      else passed++;
      exp_tgl = ~exp_tgl;
      checks++;
      if (rsp_status_o !== 2'b00) $display("FAIL rst_after_status: got %b expected 00", rsp_status_o);
      else passed++;
      repeat (3) @(negedge clk);
      checks++;
      if (mem[2] !== 32'h2222_2222) $display("FAIL rst_after_mem: got %h expected 22222222", mem[2]);
      else passed++;
   endtask

   task automatic test_back_to_back();
      int n;
      int stb0, gap0, wr0;
      stb0 = stb_rise_total; gap0 = gap_total; wr0 = wr_total;
      issue(1'b1, 4'hF, 32'h3000_000C, 32'hCAFE_F00D);
      // Second command's fields change only after the first has been latched.
      repeat (4) @(negedge clk);
      cmd_we  = 1'b0;
      cmd_adr = 32'h3000_000C;
      cmd_dat = 32'h0;
      repeat (2) @(negedge clk);
      cmd_tgl = ~cmd_tgl;
      wait_rsp(LAT, n);
      checks++;
      if (n !== LAT) $display("FAIL b2b_first_latency: got %0d expected %0d", n, LAT);
      else passed++;
      exp_tgl = ~exp_tgl;
      checks++;
      if ({rsp_status_o, rsp_dat_o} !== {2'b00, 32'h0}) $display("FAIL b2b_first: got %b/%h expected 00/00000000", rsp_status_o, rsp_dat_o);
      else passed++;
      wait_rsp(n, n);
      checks++;
      if (n !== 2 * LAT) $display("FAIL b2b_second_latency: got %0d expected %0d", n, 2 * LAT);
      else passed++;
      exp_tgl = ~exp_tgl;
      checks++;
      if ({rsp_status_o, rsp_dat_o} !== {2'b00, 32'hCAFE_F00D}) $display("FAIL b2b_second: got %b/%h expected 00/cafef00d", rsp_status_o, rsp_dat_o);
      else passed++;
      repeat (3) @(negedge clk);
      checks++;
      if (stb_rise_total - stb0 !== 2) $display("FAIL b2b_stb_pulses: got %0d expected 2", stb_rise_total - stb0);
      else passed++;
      checks++;
      if (gap_total - gap0 !== 2) $display("FAIL b2b_gap_cycles: got %0d expected 2", gap_total - gap0);
      else passed++;
      checks++;
      if (wr_total - wr0 !== 1) $display("FAIL b2b_write_count: got %0d expected 1", wr_total - wr0);
      else passed++;
      checks++;
      if (stb_cyc_diff !== 0) $display("FAIL stb_equals_cyc: got %0d differing cycles expected 0", stb_cyc_diff);
      else passed++;
   endtask

   initial begin
      test_reset();
      test_write();
      test_read();
      test_overrun_in_bus();
      test_overrun_at_completion();
      test_timeout();
      test_reset_mid_bus();
      test_back_to_back();
      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
